// File: rtl/packed_string_tx.sv
// Packed-string transmitter: serialises a slot-1-first packed string word into a byte stream.
// Build option PACKED_STRING_TX_KEEP_NUL_EN sends every slot (bit-vector semantics) instead of stripping NULs.
module packed_string_tx #(
  parameter int unsigned MAX_CHARS = 4,
  parameter int unsigned CW        = 8,
  parameter int unsigned CNT_W     = $clog2(MAX_CHARS + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    s_valid,
  output logic                    s_ready,
  input  logic [MAX_CHARS*CW-1:0] s_data,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic [CW-1:0]           m_data,
  output logic                    m_last,
  output logic                    empty_drop,
  output logic [CNT_W-1:0]        chars_left
);

  localparam int unsigned IDX_W = (MAX_CHARS > 1) ? $clog2(MAX_CHARS) : 1;

  typedef enum logic {IDLE, SEND} state_e;

  state_e                  state_q, state_d;
  logic [MAX_CHARS*CW-1:0] sr_q, sr_d;
  logic [MAX_CHARS-1:0]    mask_q, mask_d, new_mask;
  logic [CNT_W-1:0]        cnt_q, cnt_d, n;
  logic                    m_valid_q, m_last_q;
  logic [CW-1:0]           m_data_q, nxt_data;
  logic [IDX_W-1:0]        cur_idx, nxt_idx;
  logic [CW-1:0]           slots_d [MAX_CHARS];
  logic                    accept, fire;

  // Mask index 0 is slot 1 (MSB byte); the lowest set index is the next character to send.
  function automatic logic [IDX_W-1:0] first_slot(input logic [MAX_CHARS-1:0] mask);
    first_slot = '0;
    for (int i = int'(MAX_CHARS) - 1; i >= 0; i--) begin
      if (mask[i]) first_slot = IDX_W'(i);
    end
  endfunction

  assign s_ready = (state_q == IDLE) | (m_valid_q & m_ready & m_last_q);
  assign accept  = s_valid & s_ready;
  assign fire    = m_valid_q & m_ready;

  // Slots to send in the incoming word and how many there are.
  always_comb begin
    new_mask = '0;
    n        = '0;
    for (int i = 0; i < int'(MAX_CHARS); i++) begin
`ifdef PACKED_STRING_TX_KEEP_NUL_EN
      new_mask[i] = 1'b1;
`else
      new_mask[i] = |s_data[(MAX_CHARS-i)*CW-1 -: CW];
`endif
      if (new_mask[i]) n = n + CNT_W'(1);
    end
  end

  always_comb begin
    cur_idx = first_slot(mask_q);
    sr_d    = sr_q;
    mask_d  = mask_q;
    cnt_d   = cnt_q;
    state_d = state_q;
    if (accept) begin
      sr_d    = s_data;
      mask_d  = new_mask;
      cnt_d   = n;
      state_d = (n != '0) ? SEND : IDLE;
    end else if (fire) begin
      mask_d = mask_q & ~(MAX_CHARS'(1) << cur_idx);
      cnt_d  = cnt_q - CNT_W'(1);
      if (m_last_q) state_d = IDLE;
    end
    for (int i = 0; i < int'(MAX_CHARS); i++) begin
      slots_d[i] = sr_d[(MAX_CHARS-i)*CW-1 -: CW];
    end
    nxt_idx  = first_slot(mask_d);
    nxt_data = slots_d[nxt_idx];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      sr_q      <= '0;
      mask_q    <= '0;
      cnt_q     <= '0;
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
      m_last_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      sr_q      <= sr_d;
      mask_q    <= mask_d;
      cnt_q     <= cnt_d;
      m_valid_q <= (state_d == SEND);
      m_data_q  <= (state_d == SEND) ? nxt_data : '0;
      m_last_q  <= (state_d == SEND) && (cnt_d == CNT_W'(1));
    end
  end

`ifdef PACKED_STRING_TX_KEEP_NUL_EN
  assign empty_drop = 1'b0;
`else
  logic empty_drop_q;

  always_ff @(posedge clk) begin
    if (rst) empty_drop_q <= 1'b0;
    else     empty_drop_q <= accept && (n == '0);
  end

  assign empty_drop = empty_drop_q;
`endif

  assign m_valid    = m_valid_q;
  assign m_data     = m_data_q;
  assign m_last     = m_last_q;
  assign chars_left = cnt_q;

endmodule

// File: tb/tb_packed_string_tx.sv
// Directed self-checking bench for packed_string_tx (MAX_CHARS=4).
module tb_packed_string_tx;

  logic        clk = 1'b0;
  logic        rst;
  logic        s_valid;
  logic        s_ready;
  logic [31:0] s_data;
  logic        m_valid;
  logic        m_ready;
  logic [7:0]  m_data;
  logic        m_last;
  logic        empty_drop;
  logic [2:0]  chars_left;

  int n_checks = 0;
  int n_err    = 0;

  packed_string_tx dut (
    .clk        (clk),
    .rst        (rst),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_data     (s_data),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data),
    .m_last     (m_last),
    .empty_drop (empty_drop),
    .chars_left (chars_left)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a word and hold it until the handshake edge has passed.
  task automatic send_word(input logic [31:0] d);
    int budget;
    budget  = 0;
    s_valid = 1'b1;
    s_data  = d;
    while (!s_ready && budget < 20) begin
      step();
      budget++;
    end
    check("s_ready_wait", 32'(s_ready), 32'd1);
    step();
    s_valid = 1'b0;
  endtask

  // Check the beat currently presented, then let it transfer (m_ready=1).
  task automatic expect_beat(input logic [7:0] d, input logic last, input logic [2:0] left);
    check("beat_valid", 32'(m_valid), 32'd1);
    check("beat_data",  32'(m_data),  32'(d));
    check("beat_last",  32'(m_last),  32'(last));
    check("beat_left",  32'(chars_left), 32'(left));
    check("beat_drop",  32'(empty_drop), 32'd0);
    step();
  endtask

  task automatic expect_idle(input string tag);
    check({tag, "_valid"}, 32'(m_valid), 32'd0);
    check({tag, "_ready"}, 32'(s_ready), 32'd1);
    check({tag, "_left"},  32'(chars_left), 32'd0);
  endtask

  initial begin
    rst     = 1'b1;
    s_valid = 1'b0;
    s_data  = '0;
    m_ready = 1'b1;
    step();
    step();
    check("rst_valid", 32'(m_valid), 32'd0);
    check("rst_data",  32'(m_data),  32'd0);
    check("rst_last",  32'(m_last),  32'd0);
    check("rst_drop",  32'(empty_drop), 32'd0);
    check("rst_left",  32'(chars_left), 32'd0);
    check("rst_ready", 32'(s_ready), 32'd1);
    rst = 1'b0;
    step();

    // "ello" at full rate
    send_word(32'h656C6C6F);
    expect_beat(8'h65, 1'b0, 3'd4);
    expect_beat(8'h6C, 1'b0, 3'd3);
    expect_beat(8'h6C, 1'b0, 3'd2);
    expect_beat(8'h6F, 1'b1, 3'd1);
    expect_idle("ello_end");

`ifdef PACKED_STRING_TX_KEEP_NUL_EN
    // Every slot is sent, NULs included
    send_word(32'h0048_0000);
    expect_beat(8'h00, 1'b0, 3'd4);
    expect_beat(8'h48, 1'b0, 3'd3);
    expect_beat(8'h00, 1'b0, 3'd2);
    expect_beat(8'h00, 1'b1, 3'd1);
    expect_idle("keep_end");
    send_word(32'h0000_0000);
    for (int i = 4; i >= 1; i--) expect_beat(8'h00, i == 1, 3'(i));
    expect_idle("zero_end");
`else
    // Interior and trailing NULs stripped, no bubble
    send_word(32'h4100_4200);
    expect_beat(8'h41, 1'b0, 3'd2);
    expect_beat(8'h42, 1'b1, 3'd1);
    expect_idle("anb_end");

    // All-NUL word
    send_word(32'h0000_0000);
    check("zero_drop",  32'(empty_drop), 32'd1);
    check("zero_valid", 32'(m_valid), 32'd0);
    check("zero_ready", 32'(s_ready), 32'd1);
    step();
    check("zero_drop_off", 32'(empty_drop), 32'd0);
    check("zero_valid2",   32'(m_valid), 32'd0);
`endif

    // Stall on second beat, then back-to-back word on the last beat
    send_word(32'h656C6C6F);
    expect_beat(8'h65, 1'b0, 3'd4);
    m_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("stall_valid", 32'(m_valid), 32'd1);
      check("stall_data",  32'(m_data),  32'h6C);
      check("stall_left",  32'(chars_left), 32'd3);
      check("stall_last",  32'(m_last), 32'd0);
      step();
    end
    m_ready = 1'b1;
    expect_beat(8'h6C, 1'b0, 3'd3);
    expect_beat(8'h6C, 1'b0, 3'd2);
    check("b2b_data", 32'(m_data), 32'h6F);
    check("b2b_last", 32'(m_last), 32'd1);
    s_valid = 1'b1;
    s_data  = 32'h4849_0000;
    check("b2b_ready", 32'(s_ready), 32'd1);
    step();
    s_valid = 1'b0;
`ifdef PACKED_STRING_TX_KEEP_NUL_EN
    expect_beat(8'h48, 1'b0, 3'd4);
    expect_beat(8'h49, 1'b0, 3'd3);
    expect_beat(8'h00, 1'b0, 3'd2);
    expect_beat(8'h00, 1'b1, 3'd1);
`else
    expect_beat(8'h48, 1'b0, 3'd2);
    expect_beat(8'h49, 1'b1, 3'd1);
`endif
    expect_idle("b2b_end");

    // Reset mid-word discards it
    send_word(32'h656C6C6F);
    expect_beat(8'h65, 1'b0, 3'd4);
    expect_beat(8'h6C, 1'b0, 3'd3);
    rst = 1'b1;
    step();
    rst = 1'b0;
    expect_idle("midrst");
    check("midrst_data", 32'(m_data), 32'd0);
    check("midrst_last", 32'(m_last), 32'd0);
    step();
    check("midrst_quiet", 32'(m_valid), 32'd0);
    send_word(32'h656C6C6F);
    expect_beat(8'h65, 1'b0, 3'd4);
    expect_beat(8'h6C, 1'b0, 3'd3);
    expect_beat(8'h6C, 1'b0, 3'd2);
    expect_beat(8'h6F, 1'b1, 3'd1);
    expect_idle("post_rst_end");

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
